// File: rtl/rsa_decrypt_core.sv
// rsa_decrypt_core: computes P = C^d mod n with right-to-left binary
// square-and-multiply. Every modular product goes through one sequential
// restoring shift-subtract reducer, so there is no combinational divider.
// Optional build macro RSA_DECRYPT_EARLY_EXIT_EN: stop as soon as the
// remaining exponent is zero. This gives a data-dependent latency and the
// engine is then not constant-time. Without the macro the latency is fixed.
module rsa_decrypt_core #(
    parameter  int WIDTH   = 16,
    localparam int RED_CYC = 2*WIDTH+1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] cipher,
    input  logic [WIDTH-1:0] d_exp,
    input  logic [WIDTH-1:0] n_mod,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err_mod
);
    localparam int CW = $clog2(RED_CYC - 1);
    localparam int IW = $clog2(WIDTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] INIT  = 3'd1;  // one-cycle operand check after capture
    localparam logic [2:0] MUL   = 3'd2;  // reducer load cycle for acc*base
    localparam logic [2:0] RED_M = 3'd3;
    localparam logic [2:0] SQR   = 3'd4;  // reducer load cycle for base*base
    localparam logic [2:0] RED_S = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    logic [2:0]         state_q, state_d;
    logic [WIDTH-1:0]   base_q, acc_q, d_q, n_q, result_q;
    logic [2*WIDTH-1:0] prod_q;
    // The remainder stays below n, so WIDTH bits are enough to hold it between
    // steps. Only the shifted intermediate needs the extra bit.
    logic [WIDTH-1:0]   r_q;
    logic [CW-1:0]      red_cnt_q;
    logic [IW-1:0]      idx_q;
    logic               done_q, err_q;

    logic [WIDTH:0]     r_sh, r_step;
    logic               last_red, exp_bit, accept, exp_rest_zero;

    // A start is ignored while done is high. That IDLE cycle is the
    // back-to-back cycle.
    assign accept   = (state_q == IDLE) && start && !done_q;
    assign last_red = (red_cnt_q == CW'(RED_CYC - 2));

`ifdef RSA_DECRYPT_EARLY_EXIT_EN
    // The exponent register shifts right once per bit, so bit 0 is the current bit.
    assign exp_bit       = d_q[0];
    assign exp_rest_zero = (d_q[WIDTH-1:1] == '0);
`else
    assign exp_bit       = d_q[idx_q];
    assign exp_rest_zero = 1'b0;
`endif

    // One restoring step: bring in the next product bit, then subtract n if the result fits.
    always_comb begin
        r_sh   = {r_q, prod_q[2*WIDTH-1]};
        r_step = r_sh;
        if (r_sh >= {1'b0, n_q}) r_step = r_sh - {1'b0, n_q};
    end

    // Next-state sequencing of the square-and-multiply loop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = INIT;
            INIT: begin
                state_d = MUL;
                if (n_q == '0) state_d = DONE;
`ifdef RSA_DECRYPT_EARLY_EXIT_EN
                if (d_q == '0) state_d = DONE;
`endif
            end
            MUL:   state_d = RED_M;
            RED_M: if (last_red) state_d = exp_rest_zero ? DONE : SQR;
            SQR:   state_d = RED_S;
            RED_S: if (last_red) state_d = (idx_q == IW'(WIDTH-1)) ? DONE : MUL;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, reducer datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            acc_q     <= '0;
            d_q       <= '0;
            n_q       <= '0;
            prod_q    <= '0;
            r_q       <= '0;
            red_cnt_q <= '0;
            idx_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == DONE);
            case (state_q)
                IDLE: if (accept) begin
                    base_q <= cipher;
                    d_q    <= d_exp;
                    n_q    <= n_mod;
                    acc_q  <= (n_mod == WIDTH'(1)) ? '0 : WIDTH'(1);
                    idx_q  <= '0;
                    err_q  <= 1'b0;
                end
                MUL, SQR: begin
                    prod_q    <= (state_q == MUL)
                                 ? {{WIDTH{1'b0}}, acc_q}  * {{WIDTH{1'b0}}, base_q}
                                 : {{WIDTH{1'b0}}, base_q} * {{WIDTH{1'b0}}, base_q};
                    r_q       <= '0;
                    red_cnt_q <= '0;
                end
                RED_M, RED_S: begin
                    r_q       <= r_step[WIDTH-1:0];
                    prod_q    <= prod_q << 1;
                    red_cnt_q <= red_cnt_q + CW'(1);
                    if (last_red && state_q == RED_M) begin
                        // The multiply always runs. Only the write depends on the exponent bit.
                        if (exp_bit) acc_q <= r_step[WIDTH-1:0];
`ifdef RSA_DECRYPT_EARLY_EXIT_EN
                        d_q <= d_q >> 1;
`endif
                    end
                    if (last_red && state_q == RED_S) begin
                        base_q <= r_step[WIDTH-1:0];
                        idx_q  <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    result_q <= (n_q == '0) ? '0 : acc_q;
                    err_q    <= (n_q == '0);
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign result  = result_q;
    assign err_mod = err_q;

endmodule

// File: doc/rsa_decrypt_core.md
Name: rsa_decrypt_core

Overview:
- Client-side RSA decryption engine. Computes plaintext P = C^d mod n for a 16-bit ciphertext C, private exponent d and modulus n.
- Uses right-to-left binary square-and-multiply.
- Each modular product is reduced by a sequential shift-subtract reducer; there is no combinational divider.
- Consumes the ciphertext produced by the server-side encryption path and drives the client's plaintext sink over a start/busy/done handshake.

Parameters:
- WIDTH, 16, bit width of C, d, n and result.
- RED_CYC, 2*WIDTH+1, cycles per modular reduction (1 load + 2*WIDTH shift/subtract). Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- cipher  input  WIDTH  ciphertext C; captured when start is accepted
- d_exp  input  WIDTH  private exponent d; captured on start
- n_mod  input  WIDTH  modulus n; captured on start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when result is valid
- result  output  WIDTH  plaintext; held until the next accepted start
- err_mod  output  1  set with done when n==0; cleared on the next accepted start

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, result=0, err_mod=0; all internal registers 0. Reset mid-operation aborts immediately with no done pulse.
- Capture on start in IDLE: latch C, d, n.
  - base=C.
  - acc = 0 if n==1, else 1.
  - bit index i=0.
  - Clear err_mod.
- start outside IDLE is ignored, with no effect on the captured operands.
- States: IDLE -> MUL -> RED_M -> SQR -> RED_S -> (NEXT) -> ... -> DONE -> IDLE.
- MUL: product = acc*base (2*WIDTH bits, unsigned).
- RED_M: restoring reduction over RED_CYC cycles.
  - Cycle 0 loads the product; remainder register r has WIDTH+1 bits, init 0.
  - Each of the next 2*WIDTH cycles: r = {r, prod_msb}; prod <<= 1; if r>=n then r -= n.
  - If d[i]==1, acc <= r; otherwise acc is unchanged.
  - The multiply is always performed, so timing does not depend on d.
- SQR/RED_S: same reducer applied to base*base; base <= r.
- Sequencing: i increments after RED_S. If i==WIDTH-1, go to DONE; else return to MUL.
  - The final square is computed but unused. It is kept for constant time.
- DONE: result <= acc; done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: done is high on edge k+1+WIDTH*2*RED_CYC+1 after start is sampled at edge k. For WIDTH=16 this is k+1058.
- busy is high for every cycle strictly between acceptance and done.
- C>=n is legal: the first reduction normalises it.
- d==0 gives result = 1 mod n.
- n==0 (error case): skip computation; the cycle after acceptance go to DONE with result=0 and err_mod=1.
- A back-to-back start in the cycle done is high is ignored. start is accepted from the following IDLE cycle.
- Arithmetic is unsigned throughout. The product never overflows 2*WIDTH bits because acc and base are < 2^WIDTH.

Optional Feature:
- Macro: RSA_DECRYPT_EARLY_EXIT_EN.
- With the macro defined:
  - The captured exponent is shifted right after each bit step.
  - When the remaining exponent is 0 after RED_M, go directly to DONE, skipping the trailing square.
  - d==0 goes to DONE immediately after capture.
  - Latency becomes data-dependent and the engine is not constant-time.
- Without the macro: fixed latency as stated above.

Test Plan:
- C=2790, d=2753, n=3233, start 1 cycle -> done pulse exactly 1058 cycles later (without macro); result=65, err_mod=0, busy high throughout.
- C=4, d=13, n=497 -> result=445. With RED_CYC=33 and the macro, done is earlier; bit 3 is the last set bit.
- d=0, n=3233, C=1234 -> result=1. C=7, d=5, n=1 -> result=0.
- n=0, any C/d -> done 2 cycles after start, result=0, err_mod=1. A following valid start clears err_mod.
- During busy: pulse start with different operands, then after done rerun -> first result is unaffected; the ignored start produces no second done.
- Assert rst_n=0 at cycle 500 of an operation -> outputs 0 immediately and no done. A new start after release completes with the correct result.
